lc3_datapath_gen: RTL and testbench

- Parametrised successor to the LC-3 single-bus datapath. It contains the PC, IR, MAR, MDR, register file, ALU, condition codes, BEN, PSR and the supervisor/user stack-pointer bank.
- The microsequencer drives it through decoded control fields, one microstate per accepted step.
- New over the previous generation:
  - generic word width and register count;
  - stall-based memory handshake;
  - full PSR and stack-switch support;
  - a deterministic bus with no tri-state.

---
 rtl/lc3_datapath_gen_if.sv | 41 ++++
 rtl/lc3_datapath_gen.sv | 200 ++++++++++++++++++++
 tb/tb_lc3_datapath_gen.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_datapath_gen_if.sv
// Control-field and memory handshake bundle between the microsequencer and the LC-3 datapath.
interface lc3_datapath_gen_if #(
  parameter int WIDTH = 16
);
  logic             cs_valid;
  logic [2:0]       gate_sel;
  logic [9:0]       ld_mask;
  logic [1:0]       pcmux;
  logic [1:0]       drmux;
  logic [1:0]       sr1mux;
  logic [1:0]       addr2mux;
  logic [1:0]       spmux;
  logic [1:0]       aluk;
  logic             addr1mux;
  logic             marmux;
  logic             mio_en;
  logic             r_w;
  logic [1:0]       vecmux;
  logic [WIDTH-1:0] ir_out;
  logic             ben;
  logic             psr_priv;
  logic             stall;
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ready;

  modport master (
    output cs_valid, gate_sel, ld_mask, pcmux, drmux, sr1mux, addr2mux, spmux, aluk,
           addr1mux, marmux, mio_en, r_w, vecmux, mem_rdata, mem_ready,
    input  ir_out, ben, psr_priv, stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cs_valid, gate_sel, ld_mask, pcmux, drmux, sr1mux, addr2mux, spmux, aluk,
           addr1mux, marmux, mio_en, r_w, vecmux, mem_rdata, mem_ready,
    output ir_out, ben, psr_priv, stall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lc3_datapath_gen.sv
// LC-3 single-bus datapath: PC/IR/MAR/MDR, register file, ALU, PSR and SP bank.
// One microstep per accepted edge; memory steps stall until mem_ready completes the request.
module lc3_datapath_gen #(
  parameter int          WIDTH    = 16,
  parameter int          NREGS    = 8,
  parameter logic [15:0] RESET_PC = 16'h0200,
  parameter logic [7:0]  VEC_BASE = 8'h01
) (
  input logic               clk,
  input logic               reset,
  lc3_datapath_gen_if.slave cs
);
  localparam int               RW        = $clog2(NREGS);
  localparam logic [RW-1:0]    SP_IDX    = RW'(6);
  localparam logic [RW-1:0]    LR_IDX    = RW'(7);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] PSR_MASK  = WIDTH'(16'h8707);
  localparam logic [WIDTH-1:0] PSR_RESET = WIDTH'(16'h8002);

  localparam logic [2:0] G_NONE = 3'd0;
  localparam logic [2:0] G_ALU  = 3'd1;
  localparam logic [2:0] G_MARM = 3'd2;
  localparam logic [2:0] G_PC   = 3'd3;
  localparam logic [2:0] G_MDR  = 3'd4;
  localparam logic [2:0] G_VEC  = 3'd5;
  localparam logic [2:0] G_PCM1 = 3'd6;
  localparam logic [2:0] G_PSR  = 3'd7;

  logic [WIDTH-1:0] pc, ir, mar, mdr, psr, ssp, usp;
  logic [WIDTH-1:0] regs [NREGS];
  logic             ben_q;
  logic             mem_req_q;

  logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc, ld_psr, ld_ssp, ld_usp;
  assign {ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc, ld_psr, ld_ssp, ld_usp} = cs.ld_mask;

  logic [RW-1:0]    sr1_idx, dr_idx, sr2_idx;
  logic [WIDTH-1:0] imm5, off6, off9, off11;
  logic [WIDTH-1:0] sr1, sr2, alu, addr1, addr2, adder, marmux_val, vec_val;
  logic [WIDTH-1:0] bus, pc_next, sp_next;
  logic [7:0]       vec8;
  logic [2:0]       nzp;
  logic             mem_op, mem_done, stall, accept, psr_load, sp_path;

  assign imm5  = {{(WIDTH-5){ir[4]}}, ir[4:0]};
  assign off6  = {{(WIDTH-6){ir[5]}}, ir[5:0]};
  assign off9  = {{(WIDTH-9){ir[8]}}, ir[8:0]};
  assign off11 = {{(WIDTH-11){ir[10]}}, ir[10:0]};

  always_comb begin
    sr1_idx = SP_IDX;
    case (cs.sr1mux)
      2'd0:    sr1_idx = RW'(ir[11:9]);
      2'd1:    sr1_idx = RW'(ir[8:6]);
      default: sr1_idx = SP_IDX;
    endcase
    dr_idx = SP_IDX;
    case (cs.drmux)
      2'd0:    dr_idx = RW'(ir[11:9]);
      2'd1:    dr_idx = LR_IDX;
      default: dr_idx = SP_IDX;
    endcase
  end

  assign sr2_idx = RW'(ir[2:0]);
  assign sr1     = regs[sr1_idx];
  assign sr2     = ir[5] ? imm5 : regs[sr2_idx];

  always_comb begin
    alu = sr1;
    case (cs.aluk)
      2'd0:    alu = sr1 + sr2;
      2'd1:    alu = sr1 & sr2;
      2'd2:    alu = ~sr1;
      default: alu = sr1;
    endcase
  end

  assign addr1 = cs.addr1mux ? sr1 : pc;

  always_comb begin
    addr2 = '0;
    case (cs.addr2mux)
      2'd0:    addr2 = '0;
      2'd1:    addr2 = off6;
      2'd2:    addr2 = off9;
      default: addr2 = off11;
    endcase
  end

  assign adder      = addr1 + addr2;
  assign marmux_val = cs.marmux ? adder : WIDTH'(ir[7:0]);

  always_comb begin
    vec8 = 8'h00;
    case (cs.vecmux)
      2'd0:    vec8 = ir[7:0];
      2'd2:    vec8 = 8'h01;
      default: vec8 = 8'h00;
    endcase
  end

  assign vec_val = WIDTH'({VEC_BASE, vec8});

  // Plain mux instead of tri-state gates: unselected sources never reach the bus.
  always_comb begin
    bus = '0;
    case (cs.gate_sel)
      G_NONE:  bus = '0;
      G_ALU:   bus = alu;
      G_MARM:  bus = marmux_val;
      G_PC:    bus = pc;
      G_MDR:   bus = mdr;
      G_VEC:   bus = vec_val;
      G_PCM1:  bus = pc - ONE;
      G_PSR:   bus = psr;
      default: bus = '0;
    endcase
  end

  always_comb begin
    pc_next = pc;
    case (cs.pcmux)
      2'd0:    pc_next = pc + ONE;
      2'd1:    pc_next = bus;
      2'd2:    pc_next = adder;
      default: pc_next = pc;
    endcase
    sp_next = regs[SP_IDX];
    case (cs.spmux)
      2'd0:    sp_next = regs[SP_IDX] + ONE;
      2'd1:    sp_next = regs[SP_IDX] - ONE;
      2'd2:    sp_next = ssp;
      default: sp_next = usp;
    endcase
  end

  assign nzp      = {bus[WIDTH-1], bus == '0, ~bus[WIDTH-1] & (bus != '0)};
  assign psr_load = ld_psr & (cs.gate_sel != G_NONE);
  assign sp_path  = (cs.gate_sel == G_NONE) & cs.drmux[1];

  // A memory step is held off until the request it raised sees mem_ready.
  assign mem_op   = cs.cs_valid & cs.mio_en & (ld_mdr | cs.r_w);
  assign mem_done = mem_req_q & cs.mem_ready;
  assign stall    = mem_op & ~mem_done;
  assign accept   = cs.cs_valid & ~stall;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc        <= WIDTH'(RESET_PC);
      ir        <= '0;
      mar       <= '0;
      mdr       <= '0;
      psr       <= PSR_RESET;
      ssp       <= '0;
      usp       <= '0;
      ben_q     <= 1'b0;
      mem_req_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (mem_done)    mem_req_q <= 1'b0;
      else if (mem_op) mem_req_q <= 1'b1;

      if (accept) begin
        if (ld_mar) mar <= bus;
        if (ld_mdr) begin
          if (!cs.mio_en)   mdr <= bus;
          else if (!cs.r_w) mdr <= cs.mem_rdata;
        end
        if (ld_ir)  ir <= bus;
        if (ld_ben) ben_q <= |(ir[11:9] & psr[2:0]);
        if (ld_pc)  pc <= pc_next;
        if (ld_reg) begin
          if (sp_path) regs[SP_IDX] <= sp_next;
          else         regs[dr_idx] <= bus;
        end
        if (psr_load)   psr <= bus & PSR_MASK;
        else if (ld_cc) psr[2:0] <= nzp;
        if (ld_ssp) ssp <= regs[SP_IDX];
        if (ld_usp) usp <= regs[SP_IDX];
      end
    end
  end

  assign cs.ir_out    = ir;
  assign cs.ben       = ben_q;
  assign cs.psr_priv  = psr[15];
  assign cs.stall     = stall;
  assign cs.mem_req   = mem_req_q;
  assign cs.mem_we    = mem_req_q & cs.r_w;
  assign cs.mem_addr  = mar;
  assign cs.mem_wdata = mdr;

  // The sequencer must hold its step while a request is outstanding.
  property p_fields_hold;
    @(posedge clk) disable iff (!reset)
      (mem_req_q && !cs.mem_ready) |=> $stable({cs.cs_valid, cs.gate_sel, cs.ld_mask, cs.mio_en, cs.r_w});
  endproperty
  a_fields_hold: assert property (p_fields_hold);
endmodule

// File: tb/tb_lc3_datapath_gen.sv
// Randomized bench for lc3_datapath_gen against an architectural-level model of the datapath.
module tb_lc3_datapath_gen;
  localparam logic [9:0] L_MAR = 10'h200, L_MDR = 10'h100, L_IR  = 10'h080, L_BEN = 10'h040,
                         L_REG = 10'h020, L_CC  = 10'h010, L_PC  = 10'h008, L_PSR = 10'h004,
                         L_SSP = 10'h002, L_USP = 10'h001;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lc3_datapath_gen_if #(.WIDTH(16)) bus_if ();
  lc3_datapath_gen #(.WIDTH(16), .NREGS(8), .RESET_PC(16'h0200), .VEC_BASE(8'h01)) dut (
    .clk(clk), .reset(reset), .cs(bus_if)
  );

  int   errors = 0;
  int   checks = 0;
  int   stall_seen = 0;
  bit   chk_on = 1'b0;
  logic exp_stall = 1'b0, exp_req = 1'b0, exp_we = 1'b0;

  logic [15:0] m_pc, m_ir, m_mar, m_mdr, m_psr, m_ssp, m_usp;
  logic [15:0] m_r [8];
  logic        m_ben;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] sx(input logic [15:0] v, input int b);
    int t;
    t = int'(v) << (32 - b);
    t = t >>> (32 - b);
    return t[15:0];
  endfunction

  task automatic model_reset();
    m_pc = 16'h0200; m_ir = 0; m_mar = 0; m_mdr = 0; m_psr = 16'h8002;
    m_ssp = 0; m_usp = 0; m_ben = 0;
    for (int i = 0; i < 8; i++) m_r[i] = 0;
  endtask

  // Architectural effect of one accepted step, all sources taken from pre-step state.
  task automatic model_step();
    logic [15:0] s1, s2, alu, a1, a2, adr, b, spv;
    logic [2:0]  si, di;
    logic [7:0]  v8;
    logic [9:0]  l;
    l  = bus_if.ld_mask;
    si = (bus_if.sr1mux == 0) ? m_ir[11:9] : (bus_if.sr1mux == 1) ? m_ir[8:6] : 3'd6;
    di = (bus_if.drmux == 0) ? m_ir[11:9] : (bus_if.drmux == 1) ? 3'd7 : 3'd6;
    s1 = m_r[si];
    s2 = m_ir[5] ? sx(m_ir, 5) : m_r[m_ir[2:0]];
    case (bus_if.aluk)
      2'd0: alu = s1 + s2;
      2'd1: alu = s1 & s2;
      2'd2: alu = ~s1;
      default: alu = s1;
    endcase
    a1 = bus_if.addr1mux ? s1 : m_pc;
    case (bus_if.addr2mux)
      2'd0: a2 = 16'h0000;
      2'd1: a2 = sx(m_ir, 6);
      2'd2: a2 = sx(m_ir, 9);
      default: a2 = sx(m_ir, 11);
    endcase
    adr = a1 + a2;
    v8 = (bus_if.vecmux == 0) ? m_ir[7:0] : (bus_if.vecmux == 2) ? 8'h01 : 8'h00;
    case (bus_if.gate_sel)
      3'd0: b = 16'h0000;
      3'd1: b = alu;
      3'd2: b = bus_if.marmux ? adr : {8'h00, m_ir[7:0]};
      3'd3: b = m_pc;
      3'd4: b = m_mdr;
      3'd5: b = {8'h01, v8};
      3'd6: b = m_pc - 16'd1;
      default: b = m_psr;
    endcase
    case (bus_if.spmux)
      2'd0: spv = m_r[6] + 16'd1;
      2'd1: spv = m_r[6] - 16'd1;
      2'd2: spv = m_ssp;
      default: spv = m_usp;
    endcase
    if (l[6]) m_ben = (m_ir[11] & m_psr[2]) | (m_ir[10] & m_psr[1]) | (m_ir[9] & m_psr[0]);
    if (l[1]) m_ssp = m_r[6];
    if (l[0]) m_usp = m_r[6];
    if (l[3]) begin
      if (bus_if.pcmux == 0) m_pc = m_pc + 16'd1;
      else if (bus_if.pcmux == 1) m_pc = b;
      else if (bus_if.pcmux == 2) m_pc = adr;
    end
    if (l[9]) m_mar = b;
    if (l[8]) begin
      if (!bus_if.mio_en) m_mdr = b;
      else if (!bus_if.r_w) m_mdr = bus_if.mem_rdata;
    end
    if (l[5]) begin
      if (bus_if.gate_sel == 0 && bus_if.drmux >= 2) m_r[6] = spv;
      else m_r[di] = b;
    end
    if (l[2] && bus_if.gate_sel != 0) m_psr = b & 16'h8707;
    else if (l[4]) m_psr[2:0] = b[15] ? 3'b100 : (b == 0) ? 3'b010 : 3'b001;
    if (l[7]) m_ir = b;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      if (bus_if.stall) stall_seen++;
      chk("ir_out", bus_if.ir_out, m_ir);
      chk("ben", 16'(bus_if.ben), 16'(m_ben));
      chk("psr_priv", 16'(bus_if.psr_priv), 16'(m_psr[15]));
      chk("stall", 16'(bus_if.stall), 16'(exp_stall));
      chk("mem_req", 16'(bus_if.mem_req), 16'(exp_req));
      chk("mem_we", 16'(bus_if.mem_we), 16'(exp_we));
      chk("mem_addr", bus_if.mem_addr, m_mar);
      chk("mem_wdata", bus_if.mem_wdata, m_mdr);
    end
  end

  task automatic tick();
    @(posedge clk);
    if (!reset) model_reset();
    else if (bus_if.cs_valid && !exp_stall) model_step();
    #1;
  endtask

  task automatic set_idle();
    bus_if.cs_valid = 0; bus_if.gate_sel = 0; bus_if.ld_mask = 0; bus_if.pcmux = 0;
    bus_if.drmux = 0; bus_if.sr1mux = 0; bus_if.addr2mux = 0; bus_if.spmux = 0;
    bus_if.aluk = 0; bus_if.addr1mux = 0; bus_if.marmux = 0; bus_if.mio_en = 0;
    bus_if.r_w = 0; bus_if.vecmux = 0; bus_if.mem_ready = 0; bus_if.mem_rdata = 0;
    exp_stall = 0; exp_req = 0; exp_we = 0;
  endtask

  task automatic step();
    bus_if.cs_valid = 1;
    tick();
    set_idle();
  endtask

  // Memory step: one cycle before the request rises, waitc idle-ready cycles, then completion.
  task automatic mem_seq(input int waitc, input logic [15:0] rd);
    bus_if.cs_valid = 1;
    exp_stall = 1; exp_req = 0; exp_we = 0;
    bus_if.mem_ready = 1; bus_if.mem_rdata = 16'($urandom);
    tick();
    bus_if.mem_ready = 0;
    for (int i = 0; i < waitc; i++) begin
      exp_req = 1; exp_we = bus_if.r_w; exp_stall = 1; bus_if.mem_rdata = 16'($urandom);
      tick();
    end
    exp_req = 1; exp_we = bus_if.r_w; exp_stall = 0;
    bus_if.mem_ready = 1; bus_if.mem_rdata = rd;
    tick();
    set_idle();
  endtask

  task automatic mem_read(input logic [15:0] v, input int waitc);
    bus_if.mio_en = 1; bus_if.r_w = 0; bus_if.ld_mask = L_MDR;
    mem_seq(waitc, v);
  endtask

  task automatic show(input string name, input logic [2:0] g, input logic [1:0] s1m, input logic [15:0] expv);
    bus_if.gate_sel = g; bus_if.sr1mux = s1m; bus_if.aluk = 2'd3; bus_if.ld_mask = L_MAR;
    step();
    chk(name, bus_if.mem_addr, expv);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    set_idle();
    reset = 0;
    tick();
    chk_on = 1;
    tick();
    reset = 1;
    chk("rst_priv", 16'(bus_if.psr_priv), 16'd1);
    chk("rst_req", 16'(bus_if.mem_req), 16'd0);
    chk("rst_stall", 16'(bus_if.stall), 16'd0);
    chk("rst_mar", bus_if.mem_addr, 16'h0000);

    bus_if.gate_sel = 3; bus_if.ld_mask = L_MAR | L_PC; bus_if.pcmux = 0;
    step();
    chk("mar_pc", bus_if.mem_addr, 16'h0200);
    show("pc_inc", 3'd3, 2'd0, 16'h0201);
    show("psr_rst", 3'd7, 2'd0, 16'h8002);
    bus_if.vecmux = 2;
    show("vec", 3'd5, 2'd0, 16'h0101);

    mem_read(16'h1262, 0);
    bus_if.gate_sel = 4; bus_if.ld_mask = L_IR; step();
    chk("ir_load", bus_if.ir_out, 16'h1262);
    mem_read(16'hFFFE, 1);
    bus_if.gate_sel = 4; bus_if.ld_mask = L_REG | L_CC; step();
    show("r1_set", 3'd1, 2'd1, 16'hFFFE);
    show("cc_n", 3'd7, 2'd0, 16'h8004);
    bus_if.gate_sel = 1; bus_if.aluk = 0; bus_if.sr1mux = 1; bus_if.ld_mask = L_REG | L_CC; step();
    show("add_r1", 3'd1, 2'd1, 16'h0000);
    show("cc_z", 3'd7, 2'd0, 16'h8002);
    mem_read(16'h0400, 0);
    bus_if.gate_sel = 4; bus_if.ld_mask = L_IR; step();
    bus_if.ld_mask = L_BEN; step();
    chk("ben_z", 16'(bus_if.ben), 16'd1);
    mem_read(16'h0800, 0);
    bus_if.gate_sel = 4; bus_if.ld_mask = L_IR; step();
    bus_if.ld_mask = L_BEN; step();
    chk("ben_n_clear", 16'(bus_if.ben), 16'd0);

    stall_seen = 0;
    bus_if.mio_en = 1; bus_if.r_w = 0; bus_if.gate_sel = 3; bus_if.ld_mask = L_MDR | L_MAR;
    mem_seq(3, 16'hABCD);
    chk("rd_stall_cycles", 16'(stall_seen), 16'd4);
    chk("rd_mdr", bus_if.mem_wdata, 16'hABCD);
    chk("rd_mar", bus_if.mem_addr, 16'h0201);

    mem_read(16'h0500, 0);
    bus_if.gate_sel = 4; bus_if.drmux = 2; bus_if.ld_mask = L_REG; step();
    bus_if.ld_mask = L_SSP; step();
    mem_read(16'h3000, 0);
    bus_if.gate_sel = 4; bus_if.drmux = 2; bus_if.ld_mask = L_REG; step();
    bus_if.drmux = 2; bus_if.spmux = 1; bus_if.ld_mask = L_REG; step();
    show("sp_dec", 3'd1, 2'd2, 16'h2FFF);
    bus_if.ld_mask = L_USP; step();
    bus_if.drmux = 2; bus_if.spmux = 2; bus_if.ld_mask = L_REG; step();
    show("sp_ssp", 3'd1, 2'd2, 16'h0500);
    bus_if.drmux = 2; bus_if.spmux = 3; bus_if.ld_mask = L_REG; step();
    show("sp_usp", 3'd1, 2'd2, 16'h2FFF);
    bus_if.drmux = 2; bus_if.spmux = 0; bus_if.ld_mask = L_REG; step();
    show("sp_inc", 3'd1, 2'd2, 16'h3000);

    bus_if.cs_valid = 1; bus_if.mio_en = 1; bus_if.r_w = 1; bus_if.gate_sel = 3; bus_if.ld_mask = L_MAR;
    exp_stall = 1; exp_req = 0; exp_we = 0;
    tick();
    exp_req = 1; exp_we = 1;
    tick();
    reset = 0;
    tick();
    reset = 1;
    set_idle();
    chk("abort_req", 16'(bus_if.mem_req), 16'd0);
    chk("abort_mdr", bus_if.mem_wdata, 16'h0000);
    chk("abort_mar", bus_if.mem_addr, 16'h0000);
    bus_if.gate_sel = 3; bus_if.ld_mask = L_MAR | L_PC; bus_if.pcmux = 0;
    step();
    chk("post_rst_pc", bus_if.mem_addr, 16'h0200);
    show("post_rst_inc", 3'd3, 2'd0, 16'h0201);

    for (int k = 0; k < 500; k++) begin
      bus_if.gate_sel = 3'($urandom_range(0, 7));
      bus_if.ld_mask  = 10'($urandom);
      bus_if.pcmux    = 2'($urandom); bus_if.drmux  = 2'($urandom);
      bus_if.sr1mux   = 2'($urandom); bus_if.addr2mux = 2'($urandom);
      bus_if.spmux    = 2'($urandom); bus_if.aluk   = 2'($urandom);
      bus_if.addr1mux = 1'($urandom); bus_if.marmux = 1'($urandom);
      bus_if.vecmux   = 2'($urandom);
      if (bus_if.gate_sel == 0) bus_if.ld_mask[2] = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        bus_if.mio_en = 1;
        bus_if.r_w = 1'($urandom);
        bus_if.ld_mask[8] = ~bus_if.r_w;
        mem_seq($urandom_range(0, 4), 16'($urandom));
      end else begin
        bus_if.mio_en = 1'($urandom);
        if (bus_if.mio_en) begin bus_if.r_w = 0; bus_if.ld_mask[8] = 1'b0; end
        bus_if.mem_ready = 1'($urandom);
        bus_if.mem_rdata = 16'($urandom);
        bus_if.cs_valid = ($urandom_range(0, 7) != 0);
        exp_stall = 0; exp_req = 0; exp_we = 0;
        tick();
        set_idle();
      end
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
